// File: rtl/priority_pkg.sv
// Shared state encoding and width helper for the priority encoder drain block.
package priority_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/priority_encoder_core.sv
// Combinational N-to-log2(N) priority encoder, direction chosen by MSB_FIRST.
module priority_encoder_core
    import priority_pkg::*;
#(
    parameter int N = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Later matches overwrite earlier ones, so scan toward the winning end.
    always_comb begin
        idx = '0;
        any = |vec;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_encoder_drain.sv
// Live priority encoder plus a drain engine that emits every captured
// request index, one per handshake, in priority order.
module priority_encoder_drain
    import priority_pkg::*;
#(
    parameter int N = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] x,
    input  logic         load,
    input  logic         out_ready,
    output logic [W-1:0] y_live,
    output logic         live_valid,
    output logic [W-1:0] y,
    output logic         out_valid,
    output logic         busy,
    output logic         none,
    output logic [W:0]   count
);

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W:0]   count_q, count_d;
    logic         none_q, none_d;

    logic [W-1:0] live_idx, drain_idx;
    logic         live_any, drain_any;
    logic         xfer;
    logic [N-1:0] clr_mask;
    logic [N-1:0] pend_left;

    priority_encoder_core #(.N(N), .MSB_FIRST(MSB_FIRST)) u_live (
        .vec (x),
        .idx (live_idx),
        .any (live_any)
    );

    priority_encoder_core #(.N(N), .MSB_FIRST(MSB_FIRST)) u_drain (
        .vec (pend_q),
        .idx (drain_idx),
        .any (drain_any)
    );

    assign y_live     = en ? live_idx : '0;
    assign live_valid = en & live_any;
    assign y          = drain_idx;
    assign busy       = (state_q == SCAN);
    assign out_valid  = busy & en;
    assign none       = none_q;
    assign count      = count_q;

    assign xfer      = out_valid & out_ready & drain_any;
    assign clr_mask  = xfer ? (N'(1) << drain_idx) : '0;
    assign pend_left = pend_q & ~clr_mask;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        count_d = count_q;
        none_d  = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        if (|x) begin
                            pend_d  = x;
                            count_d = '0;
                            state_d = SCAN;
                        end else begin
                            none_d = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (xfer) begin
                        pend_d  = pend_left;
                        count_d = count_q + (W+1)'(1);
                        if (pend_left == '0) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            count_q <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            none_q  <= none_d;
        end
    end

endmodule

// File: tb/tb_priority_encoder_drain.sv
// Bench for priority_encoder_drain: N=8/MSB-first and N=16/LSB-first
// instances against a queue-based model, plus directed literal checks.
module tb_priority_encoder_drain;

    logic clk;
    logic rst, en, load, rdy;
    logic [7:0]  x8;
    logic [15:0] x16;

    logic [2:0] yl8, y8;
    logic       lv8, ov8, bz8, nn8;
    logic [3:0] cnt8;

    logic [3:0] yl16, y16;
    logic       lv16, ov16, bz16, nn16;
    logic [4:0] cnt16;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    int mq[2][$];
    int mc[2];
    bit mn[2];

    priority_encoder_drain #(.N(8), .MSB_FIRST(1'b1)) d8 (
        .clk(clk), .rst(rst), .en(en), .x(x8), .load(load),
        .out_ready(rdy), .y_live(yl8), .live_valid(lv8), .y(y8),
        .out_valid(ov8), .busy(bz8), .none(nn8), .count(cnt8)
    );

    priority_encoder_drain #(.N(16), .MSB_FIRST(1'b0)) d16 (
        .clk(clk), .rst(rst), .en(en), .x(x16), .load(load),
        .out_ready(rdy), .y_live(yl16), .live_valid(lv16), .y(y16),
        .out_valid(ov16), .busy(bz16), .none(nn16), .count(cnt16)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int nbits(input int k);
        return k ? 16 : 8;
    endfunction

    function automatic bit msb(input int k);
        return k ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [15:0] xin(input int k);
        return k ? x16 : {8'h00, x8};
    endfunction

    // Index of the winning set bit; 0 when nothing is set.
    function automatic int winner(input logic [15:0] v, input int n, input bit m);
        if (m) begin
            for (int i = n - 1; i >= 0; i--) if (v[i]) return i;
        end else begin
            for (int i = 0; i < n; i++) if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: pending requests held as an ordered list of indices.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [15:0] v;
            bit nn;
            v = xin(k);
            nn = 0;
            if (rst) begin
                mq[k].delete();
                mc[k] = 0;
            end else if (en) begin
                if (mq[k].size() == 0) begin
                    if (load) begin
                        if (v == 0) begin
                            nn = 1;
                        end else begin
                            mc[k] = 0;
                            if (msb(k)) begin
                                for (int i = nbits(k) - 1; i >= 0; i--)
                                    if (v[i]) mq[k].push_back(i);
                            end else begin
                                for (int i = 0; i < nbits(k); i++)
                                    if (v[i]) mq[k].push_back(i);
                            end
                        end
                    end
                end else if (rdy) begin
                    void'(mq[k].pop_front());
                    mc[k]++;
                end
            end
            mn[k] = rst ? 1'b0 : nn;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                int eyl, ey, bs;
                string p;
                p = k ? "n16" : "n8";
                bs = (mq[k].size() != 0);
                eyl = (en && xin(k) != 0) ? winner(xin(k), nbits(k), msb(k)) : 0;
                ey = bs ? mq[k][0] : 0;
                chk({p, ".y_live"}, k ? int'(yl16) : int'(yl8), eyl);
                chk({p, ".live_valid"}, k ? int'(lv16) : int'(lv8),
                    int'(en && xin(k) != 0));
                chk({p, ".y"}, k ? int'(y16) : int'(y8), ey);
                chk({p, ".out_valid"}, k ? int'(ov16) : int'(ov8), int'(bs && en));
                chk({p, ".busy"}, k ? int'(bz16) : int'(bz8), bs);
                chk({p, ".none"}, k ? int'(nn16) : int'(nn8), int'(mn[k]));
                chk({p, ".count"}, k ? int'(cnt16) : int'(cnt8), mc[k]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; en = 0; load = 0; rdy = 0; x8 = 0; x16 = 0;
        cyc();
        chk_on = 1;
        cyc();
        rst = 0;
        #1;
        chk("rst.y", int'(y8), 0);
        chk("rst.out_valid", int'(ov8), 0);
        chk("rst.busy", int'(bz8), 0);
        chk("rst.count", int'(cnt8), 0);
        chk("rst.none", int'(nn8), 0);

        // Full-throughput burst 7,5,2
        en = 1; x8 = 8'hA4; load = 1; rdy = 1;
        cyc(); load = 0; #1;
        chk("b.y0", int'(y8), 7);
        chk("b.ov0", int'(ov8), 1);
        cyc(); chk("b.y1", int'(y8), 5);
        cyc(); chk("b.y2", int'(y8), 2);
        cyc();
        chk("b.busy", int'(bz8), 0);
        chk("b.count", int'(cnt8), 3);

        // Backpressure holds y
        load = 1; rdy = 0;
        cyc(); load = 0;
        repeat (4) begin
            #1; chk("bp.hold", int'(y8), 7);
            cyc();
        end
        rdy = 1; #1;
        chk("bp.y7", int'(y8), 7);
        cyc(); chk("bp.y5", int'(y8), 5);
        cyc(); chk("bp.y2", int'(y8), 2);
        cyc(); chk("bp.idle", int'(bz8), 0);

        // Empty load pulses none; load during SCAN ignored
        x8 = 0; load = 1;
        cyc(); load = 0; #1;
        chk("none.pulse", int'(nn8), 1);
        chk("none.busy", int'(bz8), 0);
        cyc(); chk("none.clear", int'(nn8), 0);
        x8 = 8'hA4; load = 1; rdy = 0;
        cyc(); load = 0;
        x8 = 8'h01; load = 1;
        cyc(); load = 0; #1;
        chk("ign.y", int'(y8), 7);
        chk("ign.busy", int'(bz8), 1);
        chk("ign.none", int'(nn8), 0);
        rdy = 1;
        repeat (3) cyc();
        chk("ign.count", int'(cnt8), 3);
        chk("ign.idle", int'(bz8), 0);

        // en low mid-burst freezes the drain
        x8 = 8'hA4; load = 1; rdy = 1;
        cyc(); load = 0;
        cyc();
        en = 0; #1;
        chk("en0.ov", int'(ov8), 0);
        chk("en0.ylive", int'(yl8), 0);
        repeat (3) cyc();
        chk("en0.busy", int'(bz8), 1);
        chk("en0.y", int'(y8), 5);
        en = 1; #1;
        chk("en1.y", int'(y8), 5);
        chk("en1.ov", int'(ov8), 1);
        cyc(); chk("en1.y2", int'(y8), 2);
        cyc(); chk("en1.idle", int'(bz8), 0);

        // N=16 LSB-first, reset mid-drain
        x8 = 0; x16 = 16'h8001; load = 1; rdy = 1;
        cyc(); load = 0; #1;
        chk("l16.y0", int'(y16), 0);
        cyc();
        chk("l16.y15", int'(y16), 15);
        chk("l16.cnt", int'(cnt16), 1);
        rst = 1;
        cyc(); rst = 0; #1;
        chk("l16.rbusy", int'(bz16), 0);
        chk("l16.ry", int'(y16), 0);
        chk("l16.rcnt", int'(cnt16), 0);
        cyc(); chk("l16.stay", int'(bz16), 0);

        // Exhaustive 8-3 live truth table
        rdy = 0; load = 0; x16 = 0;
        for (int e = 0; e < 2; e++) begin
            for (int v = 0; v < 256; v++) begin
                int ev;
                en = e[0]; x8 = v[7:0];
                ev = 0;
                for (int b = 0; b < 8; b++) if (v[b]) ev = b;
                #1;
                chk("tt.y_live", int'(yl8), e ? ev : 0);
                chk("tt.valid", int'(lv8), int'(e != 0 && v != 0));
                cyc();
            end
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            en   = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 3) == 0);
            rdy  = ($urandom_range(0, 2) != 0);
            x8   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            x16  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
